// File: rtl/cond_wait_pkg.sv
// Shared slot states and the per-slot match/miss verdict for cond_wait_sched.
// Pure definitions, no state; widths up to 64 bits are supported by the verdict helper.
package cond_wait_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ARMED   = 2'd1,
    PENDING = 2'd2,
    ISSUED  = 2'd3
  } slot_state_e;

  typedef enum logic [1:0] {
    V_HOLD  = 2'd0,
    V_MATCH = 2'd1,
    V_MISS  = 2'd2
  } verdict_e;

  // d is the forward distance from the pre-step sum to the target; one step
  // lands exactly on it (match), jumps over it (miss) or falls short (hold).
  // d==0 holds, so a slot armed at equality only fires after a full wrap.
  function automatic verdict_e match_verdict(input logic [63:0] target,
                                             input logic [63:0] sum_old,
                                             input logic [63:0] step,
                                             input int unsigned w);
    logic [63:0] mask;
    logic [63:0] d;
    logic [63:0] s;
    mask = (w >= 64) ? '1 : ((64'd1 << w) - 64'd1);
    d    = (target - sum_old) & mask;
    s    = step & mask;
    if (d == s)
      return V_MATCH;
    if ((d != 64'd0) && (d < s))
      return V_MISS;
    return V_HOLD;
  endfunction

endpackage

// File: rtl/cond_wait_sched_rr_pick.sv
// Round-robin first-set selector: first request at or after ptr, wrapping.
// Purely combinational, zero latency; no flow control of its own.
module rr_pick #(
  parameter  int N  = 4,
  localparam int IW = $clog2(N)
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] ptr,
  output logic          found,
  output logic [IW-1:0] idx
);

  logic [IW-1:0] cand;

  // N is a power of two, so ptr+k wraps naturally in IW bits.
  always_comb begin
    found = 1'b0;
    idx   = '0;
    cand  = '0;
    for (int k = 0; k < N; k++) begin
      cand = ptr + IW'(k);
      if (!found && req[cand]) begin
        found = 1'b1;
        idx   = cand;
      end
    end
  end

endmodule

// File: rtl/cond_wait_sched.sv
// Wakes per-slot waiters when cnt_a+cnt_b steps exactly onto their target; skipped targets set missed.
// Match to wake_valid is two edges; the single wake token holds under wake_ready=0 and reloads with zero bubble.
module cond_wait_sched
  import cond_wait_pkg::*;
#(
  parameter  int          NUM_WAITERS = 4,
  parameter  int          CNT_W       = 32,
  parameter  int unsigned A_INIT      = 8,
  parameter  int unsigned B_INIT      = 4,
  parameter  int unsigned A_STEP      = 1,
  parameter  int unsigned B_STEP      = 2,
  localparam int          IW          = $clog2(NUM_WAITERS)
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   run,
  input  logic                   arm_valid,
  input  logic [IW-1:0]          arm_id,
  input  logic [CNT_W-1:0]       arm_target,
  output logic                   arm_ready,
  output logic                   wake_valid,
  output logic [IW-1:0]          wake_id,
  input  logic                   wake_ready,
  output logic [CNT_W-1:0]       cnt_a,
  output logic [CNT_W-1:0]       cnt_b,
  output logic [CNT_W-1:0]       sum,
  output logic [NUM_WAITERS-1:0] waiting,
  output logic [NUM_WAITERS-1:0] missed
);

  localparam logic [CNT_W-1:0] STEP = CNT_W'(A_STEP + B_STEP);

  slot_state_e           st   [NUM_WAITERS];
  logic [CNT_W-1:0]      tgt  [NUM_WAITERS];
  verdict_e              vd   [NUM_WAITERS];
  logic [NUM_WAITERS-1:0] pend;
  logic [IW-1:0]         rr_ptr;
  logic [IW-1:0]         pick_ptr;
  logic [IW-1:0]         pick_idx;
  logic                  pick_found;
  logic                  hs;

  assign sum       = cnt_a + cnt_b;
  assign arm_ready = (st[arm_id] == IDLE);
  assign hs        = wake_valid && wake_ready;

  // On a handshake the scan already starts past the slot being retired,
  // which is what keeps back-to-back tokens in round-robin order.
  assign pick_ptr = hs ? IW'(wake_id + 1'b1) : rr_ptr;

  always_comb begin
    pend    = '0;
    waiting = '0;
    for (int i = 0; i < NUM_WAITERS; i++) begin
      pend[i]    = (st[i] == PENDING);
      waiting[i] = (st[i] == ARMED);
      vd[i]      = match_verdict(64'(tgt[i]), 64'(sum), 64'(STEP), CNT_W);
    end
  end

  rr_pick #(
    .N (NUM_WAITERS)
  ) u_pick (
    .req   (pend),
    .ptr   (pick_ptr),
    .found (pick_found),
    .idx   (pick_idx)
  );

  // Arm, evaluate, retire and issue all touch different slots on any edge:
  // arm needs IDLE, evaluate needs ARMED, retire is ISSUED, issue is PENDING.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt_a      <= CNT_W'(A_INIT);
      cnt_b      <= CNT_W'(B_INIT);
      missed     <= '0;
      wake_valid <= 1'b0;
      wake_id    <= '0;
      rr_ptr     <= '0;
      for (int i = 0; i < NUM_WAITERS; i++) begin
        st[i]  <= IDLE;
        tgt[i] <= '0;
      end
    end else begin
      if (run) begin
        cnt_a <= cnt_a + CNT_W'(A_STEP);
        cnt_b <= cnt_b + CNT_W'(B_STEP);
        for (int i = 0; i < NUM_WAITERS; i++) begin
          if (st[i] == ARMED) begin
            case (vd[i])
              V_MATCH: st[i] <= PENDING;
              V_MISS: begin
                st[i]     <= IDLE;
                missed[i] <= 1'b1;
              end
              default: ;
            endcase
          end
        end
      end

      if (arm_valid && arm_ready) begin
        st[arm_id]     <= ARMED;
        tgt[arm_id]    <= arm_target;
        missed[arm_id] <= 1'b0;
      end

      if (hs) begin
        st[wake_id] <= IDLE;
        rr_ptr      <= IW'(wake_id + 1'b1);
      end

      if (!wake_valid || hs) begin
        wake_valid <= pick_found;
        if (pick_found) begin
          wake_id       <= pick_idx;
          st[pick_idx]  <= ISSUED;
        end
      end
    end
  end

endmodule

// File: tb/tb_cond_wait_sched.sv
// Directed bench for cond_wait_sched (CNT_W=8, STEP=3, reset sum 12).
// Stimulus pushes expected wake ids; a negedge monitor pops them on every handshake.
module tb_cond_wait_sched;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       run = 1'b0;
  logic       arm_valid = 1'b0;
  logic [1:0] arm_id = '0;
  logic [7:0] arm_target = '0;
  logic       arm_ready;
  logic       wake_valid;
  logic [1:0] wake_id;
  logic       wake_ready = 1'b0;
  logic [7:0] cnt_a;
  logic [7:0] cnt_b;
  logic [7:0] sum;
  logic [3:0] waiting;
  logic [3:0] missed;

  int n_chk  = 0;
  int n_pass = 0;
  int exp_q[$];

  cond_wait_sched #(
    .NUM_WAITERS (4),
    .CNT_W       (8),
    .A_INIT      (8),
    .B_INIT      (4),
    .A_STEP      (1),
    .B_STEP      (2)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .run        (run),
    .arm_valid  (arm_valid),
    .arm_id     (arm_id),
    .arm_target (arm_target),
    .arm_ready  (arm_ready),
    .wake_valid (wake_valid),
    .wake_id    (wake_id),
    .wake_ready (wake_ready),
    .cnt_a      (cnt_a),
    .cnt_b      (cnt_b),
    .sum        (sum),
    .waiting    (waiting),
    .missed     (missed)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] expv);
    n_chk++;
    if (act === expv) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d", name, act, expv);
  endtask

  // Scoreboard monitor: a handshake happens on the coming posedge.
  always @(negedge clk) begin
    int e;
    if (rst_n && wake_valid && wake_ready) begin
      if (exp_q.size() == 0) begin
        n_chk++;
        $display("FAIL wake_unexpected: got id %0d, expected no token", wake_id);
      end else begin
        e = exp_q.pop_front();
        check("wake_id_sb", 64'(wake_id), 64'(e));
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0; run = 1'b0; arm_valid = 1'b0; wake_ready = 1'b0;
    tick();
    rst_n = 1'b1;
  endtask

  task automatic arm(input int id, input int t);
    arm_id = 2'(id); arm_target = 8'(t); arm_valid = 1'b1;
    #1;
    check("arm_ready", 64'(arm_ready), 64'd1);
    tick();
    arm_valid = 1'b0;
  endtask

  task automatic run_n(input int n);
    run = 1'b1;
    repeat (n) tick();
    run = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation still running at %0t, expected finish", $time);
    $fatal(1);
  end

  initial begin
    // Reset defaults and a single wake after four steps.
    do_reset();
    check("rst_sum", 64'(sum), 64'd12);
    check("rst_cnt_a", 64'(cnt_a), 64'd8);
    check("rst_cnt_b", 64'(cnt_b), 64'd4);
    check("rst_wake_valid", 64'(wake_valid), 64'd0);
    check("rst_wake_id", 64'(wake_id), 64'd0);
    check("rst_waiting", 64'(waiting), 64'd0);
    check("rst_missed", 64'(missed), 64'd0);
    wake_ready = 1'b1;
    arm(0, 24);
    check("armed_waiting", 64'(waiting), 64'b0001);
    exp_q.push_back(0);
    run = 1'b1;
    for (int k = 1; k <= 4; k++) begin
      tick();
      check("step_sum", 64'(sum), 64'(12 + 3 * k));
    end
    run = 1'b0;
    check("pending_no_wake_yet", 64'(wake_valid), 64'd0);
    tick();
    check("t1_wake_valid", 64'(wake_valid), 64'd1);
    check("t1_wake_id", 64'(wake_id), 64'd0);
    tick();
    check("t1_wake_done", 64'(wake_valid), 64'd0);
    check("t1_missed", 64'(missed), 64'd0);

    // Target 13 from 12 is jumped over in one step.
    do_reset();
    arm(1, 13);
    run_n(1);
    check("skip_missed", 64'(missed), 64'b0010);
    check("skip_waiting", 64'(waiting), 64'd0);
    arm_id = 2'd1;
    #1;
    check("skip_arm_ready", 64'(arm_ready), 64'd1);
    repeat (3) tick();
    check("skip_no_wake", 64'(wake_valid), 64'd0);

    // Simultaneous matches, then pointer wrap back to slot 0.
    do_reset();
    wake_ready = 1'b1;
    arm(0, 18); arm(1, 18); arm(3, 18);
    exp_q.push_back(0); exp_q.push_back(1); exp_q.push_back(3);
    run_n(2);
    tick();
    check("sim_id0", 64'(wake_id), 64'd0);
    check("sim_v0", 64'(wake_valid), 64'd1);
    tick();
    check("sim_id1", 64'(wake_id), 64'd1);
    check("sim_v1", 64'(wake_valid), 64'd1);
    tick();
    check("sim_id3", 64'(wake_id), 64'd3);
    check("sim_v3", 64'(wake_valid), 64'd1);
    tick();
    check("sim_drained", 64'(wake_valid), 64'd0);
    arm(2, 24); arm(0, 24);
    exp_q.push_back(0); exp_q.push_back(2);
    run_n(2);
    tick();
    check("rr_first", 64'(wake_id), 64'd0);
    tick();
    check("rr_second", 64'(wake_id), 64'd2);
    tick();
    check("rr_drained", 64'(wake_valid), 64'd0);

    // Backpressure: sum is 24 here.
    wake_ready = 1'b0;
    arm(1, 27); arm(3, 30);
    run_n(1);
    tick();
    check("bp_valid", 64'(wake_valid), 64'd1);
    for (int i = 0; i < 5; i++) begin
      run = (i == 0);
      arm_valid = (i == 2); arm_id = 2'd1; arm_target = 8'd99;
      if (i == 2) begin
        #1;
        check("bp_arm_stall", 64'(arm_ready), 64'd0);
      end
      tick();
      check("bp_hold_valid", 64'(wake_valid), 64'd1);
      check("bp_hold_id", 64'(wake_id), 64'd1);
    end
    run = 1'b0; arm_valid = 1'b0;
    check("bp_second_pending", 64'(waiting), 64'd0);
    exp_q.push_back(1); exp_q.push_back(3);
    wake_ready = 1'b1;
    tick();
    check("bp_next_valid", 64'(wake_valid), 64'd1);
    check("bp_next_id", 64'(wake_id), 64'd3);
    tick();
    check("bp_drained", 64'(wake_valid), 64'd0);

    // Equal at arm, then wrap. STEP=3 passes 11->14 on the first lap, so
    // target 12 is skipped at run 86; target 5 is hit from 2 at run 83.
    do_reset();
    wake_ready = 1'b1;
    arm(2, 12); arm(1, 5);
    exp_q.push_back(1);
    run = 1'b1;
    for (int k = 1; k <= 86; k++) begin
      tick();
      if (k == 1) begin
        check("eq_still_waiting", 64'(waiting), 64'b0110);
        check("eq_no_wake", 64'(wake_valid), 64'd0);
      end
      if (k == 83) check("wrap_sum", 64'(sum), 64'd5);
      if (k == 84) check("wrap_wake_id", 64'(wake_id), 64'd1);
      if (k == 85) begin
        check("wrap_waiting", 64'(waiting), 64'b0100);
        check("wrap_missed_clear", 64'(missed), 64'd0);
      end
    end
    run = 1'b0;
    check("wrap_skip_missed", 64'(missed), 64'b0100);
    check("wrap_skip_waiting", 64'(waiting), 64'd0);
    check("wrap_sum_end", 64'(sum), 64'd14);

    // Reset with a token in flight (sum is 14).
    wake_ready = 1'b0;
    arm(3, 50); arm(0, 17);
    run_n(1);
    tick();
    check("mid_valid_before", 64'(wake_valid), 64'd1);
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    check("mid_wake_valid", 64'(wake_valid), 64'd0);
    check("mid_wake_id", 64'(wake_id), 64'd0);
    check("mid_waiting", 64'(waiting), 64'd0);
    check("mid_missed", 64'(missed), 64'd0);
    check("mid_sum", 64'(sum), 64'd12);
    wake_ready = 1'b1;
    repeat (3) tick();
    check("mid_no_wake", 64'(wake_valid), 64'd0);

    check("scoreboard_drain", 64'(exp_q.size()), 64'd0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
